// File: rtl/shift_reg.sv
// Serial-in / parallel-out SPI shift register, MSB-first, with the oldest bit
// driven on spi_miso so several instances can be daisy-chained.
module shift_reg #(
    parameter int unsigned WIDTH = 48
) (
    input  logic             reset,
    input  logic             spi_clk,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic [WIDTH-1:0] spi_regout
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // No enable: every rising edge shifts, so framing comes from clock gating upstream.
    always_comb begin
        sr_d = {sr_q[WIDTH-2:0], spi_mosi};
    end

    always_ff @(posedge spi_clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign spi_regout = sr_q;
    assign spi_miso   = sr_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg.sv
// Directed self-checking bench for shift_reg: a 48-bit instance plus two
// 8-bit instances chained MISO to MOSI.
module tb_shift_reg;

    logic        spi_clk;
    logic        reset;
    logic        spi_mosi;
    logic        spi_miso;
    logic [47:0] spi_regout;

    logic        mosi8;
    logic        chain_mid;
    logic        miso8_last;
    logic [7:0]  regout8_first;
    logic [7:0]  regout8_last;

    int checks;
    int errors;

    shift_reg #(.WIDTH(48)) u_dut (
        .reset     (reset),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .spi_regout(spi_regout)
    );

    shift_reg #(.WIDTH(8)) u_first (
        .reset     (reset),
        .spi_clk   (spi_clk),
        .spi_mosi  (mosi8),
        .spi_miso  (chain_mid),
        .spi_regout(regout8_first)
    );

    shift_reg #(.WIDTH(8)) u_last (
        .reset     (reset),
        .spi_clk   (spi_clk),
        .spi_mosi  (chain_mid),
        .spi_miso  (miso8_last),
        .spi_regout(regout8_last)
    );

    // One full clock period; returns with the clock low, mid low phase.
    task automatic tick();
        spi_clk = 1'b1;
        #5;
        spi_clk = 1'b0;
        #5;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        spi_mosi = 1'b1;
        mosi8    = 1'b1;
        reset    = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (spi_regout !== 48'h0 || spi_miso !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: regout=%h miso=%b, required regout=0 miso=0",
                     spi_regout, spi_miso);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (spi_regout !== 48'h0 || spi_miso !== 1'b0) begin
                errors++;
                $display("FAIL reset_held[%0d]: regout=%h miso=%b, required regout=0 miso=0",
                         i, spi_regout, spi_miso);
            end
        end
        reset = 1'b0;
        #1;
    endtask

    task automatic test_all_ones();
        logic [47:0] exp;
        logic        exp_miso;
        spi_mosi = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            tick();
            exp      = (k == 48) ? 48'hFFFF_FFFF_FFFF : ((48'h1 << k) - 48'h1);
            exp_miso = (k == 48);
            checks++;
            if (spi_regout !== exp) begin
                errors++;
                $display("FAIL all_ones_regout[%0d]: got %h, required %h", k, spi_regout, exp);
            end
            checks++;
            if (spi_miso !== exp_miso) begin
                errors++;
                $display("FAIL all_ones_miso[%0d]: got %b, required %b", k, spi_miso, exp_miso);
            end
        end
    endtask

    task automatic test_pattern();
        logic [47:0] pat;
        pat = 48'hA5A5_0123_F00F;
        pulse_reset();
        for (int i = 47; i >= 0; i--) begin
            spi_mosi = pat[i];
            tick();
        end
        checks++;
        if (spi_regout !== pat || spi_miso !== 1'b1) begin
            errors++;
            $display("FAIL pattern_load: regout=%h miso=%b, required regout=%h miso=1",
                     spi_regout, spi_miso, pat);
        end
        spi_mosi = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (spi_miso !== pat[46-i]) begin
                errors++;
                $display("FAIL pattern_miso[%0d]: got %b, required %b", i, spi_miso, pat[46-i]);
            end
        end
        checks++;
        if (spi_regout !== 48'hA501_23F0_0F00) begin
            errors++;
            $display("FAIL pattern_shifted: got %h, required %h", spi_regout, 48'hA501_23F0_0F00);
        end
    endtask

    task automatic test_reset_mid_frame();
        spi_mosi = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (spi_regout[19:0] !== 20'hF_FFFF) begin
            errors++;
            $display("FAIL mid_frame_prefill: got %h, required low 20 bits set", spi_regout);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (spi_regout !== 48'h0 || spi_miso !== 1'b0) begin
            errors++;
            $display("FAIL mid_frame_clear: regout=%h miso=%b, required 0", spi_regout, spi_miso);
        end
        #1;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (spi_regout !== 48'hF) begin
            errors++;
            $display("FAIL mid_frame_restart: got %h, required %h", spi_regout, 48'hF);
        end
    endtask

    task automatic test_width();
        logic [7:0] pat;
        pat = 8'h3C;
        pulse_reset();
        for (int i = 7; i >= 0; i--) begin
            mosi8 = pat[i];
            tick();
        end
        checks++;
        if (regout8_first !== 8'h3C) begin
            errors++;
            $display("FAIL width8_load: got %h, required %h", regout8_first, 8'h3C);
        end
        checks++;
        if (chain_mid !== 1'b0) begin
            errors++;
            $display("FAIL width8_miso_edge8: got %b, required 0", chain_mid);
        end
        mosi8 = 1'b1;
        tick();
        checks++;
        if (regout8_first !== 8'h79) begin
            errors++;
            $display("FAIL width8_edge9: got %h, required %h", regout8_first, 8'h79);
        end
        tick();
        checks++;
        if (regout8_first !== 8'hF3 || chain_mid !== 1'b1) begin
            errors++;
            $display("FAIL width8_edge10: regout=%h miso=%b, required regout=f3 miso=1",
                     regout8_first, chain_mid);
        end
    endtask

    task automatic test_daisy_chain();
        logic [15:0] pat;
        pat = 16'hBEEF;
        pulse_reset();
        for (int i = 15; i >= 0; i--) begin
            mosi8 = pat[i];
            tick();
        end
        // Older byte has travelled through to the far end of the chain.
        checks++;
        if (regout8_last !== 8'hBE) begin
            errors++;
            $display("FAIL chain_last: got %h, required %h", regout8_last, 8'hBE);
        end
        checks++;
        if (regout8_first !== 8'hEF) begin
            errors++;
            $display("FAIL chain_first: got %h, required %h", regout8_first, 8'hEF);
        end
        checks++;
        if (miso8_last !== 1'b1) begin
            errors++;
            $display("FAIL chain_miso: got %b, required 1", miso8_last);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        spi_clk  = 1'b0;
        reset    = 1'b0;
        spi_mosi = 1'b0;
        mosi8    = 1'b0;
        #3;
        test_reset();
        test_all_ones();
        test_pattern();
        test_reset_mid_frame();
        test_width();
        test_daisy_chain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
